cond_unit: RTL
==============

# cond_unit

Condition-code and status-flag unit that sits on the output side of the `ALU`. It accepts one ALU result per handshake, together with the ALU's CO/OVF/N/Z flags, a 4-bit condition code and a set-flags bit. It evaluates the condition against the architectural NZCV flag register, updates that register, and presents a registered, conditional writeback to the register file through a 2-entry output buffer.

## Interface
- `W`, 32, datapath width; must match the ALU.
- `clk` input 1: single clock; all state changes on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: ALU result/flags/cond present.
- `in_ready` output 1: unit can accept this cycle.
- `in_q` input W: ALU result Q.
- `in_co`, `in_ovf`, `in_n`, `in_z` input 1 each: ALU flags.
- `in_cond` input 4: condition code.
- `in_setf` input 1: update flags if the condition passes.
- `in_rd` input 5: destination register tag.
- `flag_load` input 1: overwrite the flag register (exception return).
- `flag_data` input 4: {N,Z,C,V} for `flag_load`.
- `flush` input 1: discard buffered outputs.
- `out_valid` output 1: writeback entry available.
- `out_ready` input 1: consumer takes entry.
- `out_q` output W, `out_rd` output 5: writeback data and tag.
- `out_we` output 1: condition passed; register file must write.
- `flags` output 4: current {N,Z,C,V} register.

## Operation
- Accept occurs when `in_valid & in_ready`.
- The condition is evaluated against the `flags` value before this accept. The pass function uses C=CO and V=OVF:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
- On accept with pass & `in_setf`, the flag register is loaded from {in_n, in_z, in_co, in_ovf}. Otherwise flags are unchanged.
- Every accepted op enqueues {in_q, in_rd, pass} into the buffer. Failed ops are still emitted, with `out_we`=0, so that downstream ordering and retire counts stay intact.
- `flag_load` writes `flag_data` and takes priority over a simultaneous set-flags accept. The accepted op's condition still uses the pre-edge flags.
- `flush` empties the buffer in the same edge and drops any simultaneous enqueue. Flag updates from a simultaneous accept still apply. `flush` does not affect the flag register.
- Buffer is a 2-entry FIFO with count in {0,1,2}.
  - `in_ready` = count<2. It is registered-equivalent and does not depend combinationally on `out_ready`.
  - Simultaneous enqueue and dequeue at count=2 is impossible, because `in_ready`=0.
  - At count=1, simultaneous enqueue and dequeue keeps count=1.
- `out_*` always reflect the head entry. They are don't-care when `out_valid`=0, but the implementation drives zeros.

## Timing
- Latency: accept at edge k gives `out_valid`=1 after edge k (first visible in cycle k+1) when the buffer was empty.
- Flag update is visible on `flags` in the cycle after accept. A back-to-back op accepted in that cycle sees the new flags.
- Throughput: 1 op/cycle while `out_ready`=1.
- Stall: `out_*` hold stable while `out_valid & !out_ready`.
- Reset values (asynchronous):
  - buffer empty: `out_valid`=0, `out_q`=0, `out_rd`=0, `out_we`=0.
  - `in_ready`=1.
  - `flags`=4'b0000.
  - Statistics counters = 0.
- Reset asserted mid-stream discards buffered entries. The first accept after deassertion sees flags=0.

## Configuration
- `COND_UNIT_STATS_EN` defined: adds outputs `stat_pass` and `stat_fail`, each 32 bits.
  - They count accepted ops whose condition passed or failed, including ops later flushed.
  - They saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `cond_pkg`:
  - Condition-code constants (COND_EQ…COND_NV).
  - Flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
  - Buffer depth constant (2).
- Sub-module `cond_eval`: purely combinational; inputs 4-bit cond and 4-bit flags, output pass.
- Top level holds the flag register, the FIFO and the counters.

## Test plan
- Reset, then accept cond=AL, setf=1, q=5, Z=0, N=0 -> next cycle `out_valid`=1, `out_q`=5, `out_we`=1; `flags`=0000.
- Op1 setf with Z=1 (q=0), then op2 cond=EQ q=7 back-to-back -> op2 `out_we`=1. Repeat with cond=NE -> `out_we`=0 and flags unchanged.
- Flags N=1, V=0; cond=LT setf with flags {0,0,1,1} -> passes, and `flags` becomes 0011. Next op cond=GE with V=1, N=0 -> fails.
- Hold `out_ready`=0 with 3 ops offered -> 2 accepted, `in_ready`=0, head stable. Release -> outputs drain in order with q values preserved.
- `flag_load`=1 with flag_data=1010 in the same cycle as a setf accept of Z=1 -> `flags`=1010. `flush` with 2 buffered -> `out_valid`=0 next cycle.
- `COND_UNIT_STATS_EN`: 3 passes and 2 NV ops -> `stat_pass`=3, `stat_fail`=2. Async reset mid-stream -> all counters 0 and `out_valid`=0 immediately.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared constants for the condition-code unit: condition encodings,
// NZCV bit positions within the flag register, and output buffer depth.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition evaluator: decides whether a 4-bit condition
// code passes against an {N,Z,C,V} flag value.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Condition decode against the supplied flags.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition-code / status-flag unit behind the ALU. Holds the NZCV flag
// register, evaluates each accepted op's condition against the pre-accept
// flags, and queues {q, rd, pass} into a 2-entry writeback FIFO.
// Optional build macro COND_UNIT_STATS_EN adds saturating pass/fail counters.
module cond_unit
  import cond_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_q,
  input  logic         in_co,
  input  logic         in_ovf,
  input  logic         in_n,
  input  logic         in_z,
  input  logic [3:0]   in_cond,
  input  logic         in_setf,
  input  logic [4:0]   in_rd,
  input  logic         flag_load,
  input  logic [3:0]   flag_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic [4:0]   out_rd,
  output logic         out_we,
  output logic [3:0]   flags
`ifdef COND_UNIT_STATS_EN
  ,
  output logic [31:0]  stat_pass,
  output logic [31:0]  stat_fail
`endif
);

  logic         pass;
  logic         accept;
  logic         deq;
  logic [1:0]   count;
  logic         rd_ptr;
  logic         wr_ptr;
  logic [W-1:0] q_mem  [BUF_DEPTH];
  logic [4:0]   rd_mem [BUF_DEPTH];
  logic         we_mem [BUF_DEPTH];

  cond_eval u_eval (
    .cond  (in_cond),
    .flags (flags),
    .pass  (pass)
  );

  // in_ready depends only on registered count, never on out_ready.
  assign in_ready  = (count != 2'd2);
  assign accept    = in_valid & in_ready;
  assign out_valid = (count != 2'd0);
  assign deq       = out_valid & out_ready;

  // Head entry presented to the consumer; zeros while empty.
  assign out_q  = out_valid ? q_mem[rd_ptr]  : '0;
  assign out_rd = out_valid ? rd_mem[rd_ptr] : '0;
  assign out_we = out_valid ? we_mem[rd_ptr] : 1'b0;

  // Flag register: exception-return load wins over a set-flags accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else if (flag_load) begin
      flags <= flag_data;
    end else if (accept && pass && in_setf) begin
      flags <= {in_n, in_z, in_co, in_ovf};
    end
  end

  // Writeback FIFO; flush clears it and drops any same-edge enqueue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        q_mem[i]  <= '0;
        rd_mem[i] <= '0;
        we_mem[i] <= 1'b0;
      end
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (accept) begin
        q_mem[wr_ptr]  <= in_q;
        rd_mem[wr_ptr] <= in_rd;
        we_mem[wr_ptr] <= pass;
        wr_ptr         <= !wr_ptr;
      end
      if (deq) begin
        rd_ptr <= !rd_ptr;
      end
      case ({accept, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef COND_UNIT_STATS_EN
  // Saturating pass/fail counters; flushed ops still count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pass <= '0;
      stat_fail <= '0;
    end else if (accept) begin
      if (pass && (stat_pass != 32'hFFFF_FFFF)) stat_pass <= stat_pass + 32'd1;
      if (!pass && (stat_fail != 32'hFFFF_FFFF)) stat_fail <= stat_fail + 32'd1;
    end
  end
`endif

endmodule
